logic_imm_decoder: RTL and testbench
====================================

Name: logic_imm_decoder

Overview:
- Multi-cycle decoder for the ARMv8 logical-immediate encoding (N:immr:imms).
- Expands the encoding into the 64-bit operand that the ALU's bitwise AND/OR/EOR paths consume for ANDI/ORRI/EORI.
- Sits in the decode stage ahead of the 64-bit ALU and uses a start/ready/done handshake so the pipeline can stall on it.
- Iteratively replicates the element pattern, one doubling per cycle.

Parameters:
DATA_W, 64, operand width; only 64 is supported, elaboration error otherwise.

Ports:
clk  input  1  clock; all state changes on rising edge.
reset  input  1  asynchronous, active-high reset.
start  input  1  request; accepted when start & ready at a rising edge.
n_bit  input  1  N field of encoding.
immr  input  6  rotate field.
imms  input  6  size/ones-count field.
ready  output  1  high in IDLE and DONE.
done  output  1  one-cycle pulse marking result valid.
error  output  1  encoding reserved/invalid; valid when done, held after.
wmask  output 64  decoded immediate; 0 when error.
tmask  output 64  bitfield top mask; only with TMASK_EN, else constant 0.

Behaviour:
- Reset (async, any state): state=IDLE, ready=1, done=0, error=0, wmask=0, tmask=0.
- IDLE: on accepted start, capture n_bit/immr/imms into registers; go to SIZE.
- SIZE (1 cycle):
  - len = index of highest set bit of 7-bit {n_bit, ~imms}; esize = 1<<len.
  - levels = (1<<len)-1; S = imms & levels; R = immr & levels.
  - Invalid if no bit set, len==0, or S==levels.
  - Invalid: go to DONE with error=1, wmask=0, tmask=0.
  - Valid: elem = ones(S+1) in low esize bits; go to ROTATE.
- ROTATE (1 cycle): elem = rotate right by R within esize bits; computed in a single cycle. Go to REPLICATE, or to DONE if esize==64.
- REPLICATE: each cycle elem = {elem,elem} and esize doubles. Leave for DONE when esize reaches 64, i.e. after 6-len cycles.
- DONE: done=1 for exactly this cycle; wmask/error/tmask registered on entry. Next state is IDLE, or SIZE if start is accepted in DONE.
- Outputs hold their last values until the next DONE entry or reset; they are never cleared by start alone.
- Latency, from the accepting edge to the done-high cycle:
  - valid encodings: 3+(6-len) cycles (3 for esize 64, 8 for esize 2);
  - invalid encodings: 2 cycles.
- start while not ready (SIZE/ROTATE/REPLICATE) is ignored; it does not queue.
- Input fields are sampled only on acceptance; later changes have no effect.
- Reset asserted mid-operation aborts immediately to IDLE with reset values; no done pulse.

Optional Feature:
- Macro: LOGIC_IMM_TMASK_EN.
- Defined:
  - Also build telem = ones(d+1), where d = (S-R) mod esize; telem is not rotated.
  - telem is replicated in lockstep with elem.
  - tmask is registered on DONE entry and is 0 on error.
- Undefined: no tmask datapath; tmask tied to 0. Latency is unchanged.

Decomposition:
- Package logic_imm_pkg holds:
  - the state enum typedef (IDLE, SIZE, ROTATE, REPLICATE, DONE);
  - localparam DATA_W=64 and LOG_W=6;
  - a function ones(count) returning a 64-bit low-ones mask.
- One sub-module, logic_imm_hsb: combinational highest-set-bit finder over 7 bits, returning the index and a found flag. It is reused by SIZE.

Test Plan:
- n_bit=1, immr=0, imms=0 -> wmask=0x0000000000000001, error=0, done 3 cycles after accept; tmask=0x1 with macro.
- n_bit=0, immr=0, imms=0b000111 -> wmask=0x000000FF000000FF, done 4 cycles after accept.
- n_bit=0, immr=0, imms=0b111100 -> wmask=0x5555555555555555, done 8 cycles after accept.
- n_bit=1, immr=1, imms=0 -> wmask=0x8000000000000000; with macro, tmask=0xFFFFFFFFFFFFFFFF.
- Invalid cases, each with error=1, wmask=0, done 2 cycles after accept:
  - n_bit=0, imms=0b111111;
  - n_bit=1, imms=0b111111;
  - n_bit=0, imms=0b111101.
- Control cases:
  - reset pulsed during REPLICATE -> IDLE, all outputs 0, no done pulse;
  - start held high while busy -> ignored;
  - start high in the DONE cycle -> back-to-back accept, with the next done on schedule.

Source files
------------

// File: rtl/logic_imm_pkg.sv
// Shared types and helpers for the ARMv8 logical-immediate decoder.
package logic_imm_pkg;

    localparam int DATA_W = 64;
    localparam int LOG_W  = 6;

    typedef enum logic [2:0] {
        IDLE,
        SIZE,
        ROTATE,
        REPLICATE,
        DONE
    } state_e;

    // count == 64 wraps the shift to zero, so the subtraction yields all ones
    function automatic logic [DATA_W-1:0] ones(input logic [LOG_W:0] count);
        return (DATA_W'(1) << count) - DATA_W'(1);
    endfunction

endpackage

// File: rtl/logic_imm_hsb.sv
// Combinational highest-set-bit finder over the 7-bit {N, ~imms} vector.
module logic_imm_hsb
    import logic_imm_pkg::*;
(
    input  logic [LOG_W:0] vec,
    output logic [2:0]     idx,
    output logic           found
);

    always_comb begin
        idx = '0;
        for (int unsigned i = 0; i < LOG_W + 1; i++) begin
            if (vec[i]) idx = 3'(i);
        end
    end

    assign found = |vec;

endmodule

// File: rtl/logic_imm_decoder.sv
// Multi-cycle ARMv8 logical-immediate (N:immr:imms) decoder with start/ready/done.
// Optional bitfield top mask built when LOGIC_IMM_TMASK_EN is defined.
module logic_imm_decoder
    import logic_imm_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              n_bit,
    input  logic [5:0]        immr,
    input  logic [5:0]        imms,
    output logic              ready,
    output logic              done,
    output logic              error,
    output logic [DATA_W-1:0] wmask,
    output logic [DATA_W-1:0] tmask
);

    if (DATA_W != logic_imm_pkg::DATA_W) begin : g_bad_width
        $error("logic_imm_decoder: only DATA_W=64 is supported");
    end

    state_e      state, state_d;
    logic        n_q;
    logic [5:0]  immr_q, imms_q;
    logic [5:0]  r_q, r_d;
    logic [2:0]  len_q, len_d;
    logic [63:0] elem_q, elem_d;
    logic [63:0] wmask_q, wmask_d;
    logic        error_q, error_d;

    logic [2:0]  hsb_idx;
    logic        hsb_found;
    logic [5:0]  levels, s_val, r_val;
    logic        invalid;
    logic [6:0]  esize;
    logic [63:0] rot, rep;

    logic_imm_hsb u_hsb (
        .vec   ({n_q, ~imms_q}),
        .idx   (hsb_idx),
        .found (hsb_found)
    );

    assign levels  = ~(6'h3f << hsb_idx);
    assign s_val   = imms_q & levels;
    assign r_val   = immr_q & levels;
    assign invalid = !hsb_found || (hsb_idx == 3'd0) || (s_val == levels);

    // Element lives in the low esize bits; rotation wraps within that width
    assign esize = 7'd1 << len_q;
    assign rot   = ((elem_q >> r_q) | (elem_q << (esize - {1'b0, r_q}))) & ones(esize);
    assign rep   = elem_q | (elem_q << esize);

    assign ready = (state == IDLE) || (state == DONE);
    assign done  = (state == DONE);
    assign error = error_q;
    assign wmask = wmask_q;

    always_comb begin
        state_d = state;
        len_d   = len_q;
        r_d     = r_q;
        elem_d  = elem_q;
        wmask_d = wmask_q;
        error_d = error_q;
        case (state)
            IDLE: begin
                if (start) state_d = SIZE;
            end
            SIZE: begin
                if (invalid) begin
                    state_d = DONE;
                    wmask_d = '0;
                    error_d = 1'b1;
                end else begin
                    state_d = ROTATE;
                    elem_d  = ones({1'b0, s_val} + 7'd1);
                    len_d   = hsb_idx;
                    r_d     = r_val;
                end
            end
            ROTATE: begin
                elem_d = rot;
                if (len_q == 3'(LOG_W)) begin
                    state_d = DONE;
                    wmask_d = rot;
                    error_d = 1'b0;
                end else begin
                    state_d = REPLICATE;
                end
            end
            REPLICATE: begin
                elem_d = rep;
                len_d  = len_q + 3'd1;
                if (len_q == 3'(LOG_W - 1)) begin
                    state_d = DONE;
                    wmask_d = rep;
                    error_d = 1'b0;
                end
            end
            DONE: begin
                state_d = start ? SIZE : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            n_q     <= 1'b0;
            immr_q  <= '0;
            imms_q  <= '0;
            r_q     <= '0;
            len_q   <= '0;
            elem_q  <= '0;
            wmask_q <= '0;
            error_q <= 1'b0;
        end else begin
            state   <= state_d;
            r_q     <= r_d;
            len_q   <= len_d;
            elem_q  <= elem_d;
            wmask_q <= wmask_d;
            error_q <= error_d;
            if (start && ready) begin
                n_q    <= n_bit;
                immr_q <= immr;
                imms_q <= imms;
            end
        end
    end

`ifdef LOGIC_IMM_TMASK_EN
    logic [63:0] telem_q, telem_d, tmask_q, tmask_d, trep;
    logic [5:0]  d_val;

    // Top mask element is ones(((S-R) mod esize)+1), never rotated
    assign d_val = (s_val - r_val) & levels;
    assign trep  = telem_q | (telem_q << esize);
    assign tmask = tmask_q;

    always_comb begin
        telem_d = telem_q;
        tmask_d = tmask_q;
        case (state)
            SIZE: begin
                telem_d = ones({1'b0, d_val} + 7'd1);
                if (invalid) tmask_d = '0;
            end
            ROTATE: begin
                if (len_q == 3'(LOG_W)) tmask_d = telem_q;
            end
            REPLICATE: begin
                telem_d = trep;
                if (len_q == 3'(LOG_W - 1)) tmask_d = trep;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            telem_q <= '0;
            tmask_q <= '0;
        end else begin
            telem_q <= telem_d;
            tmask_q <= tmask_d;
        end
    end
`else
    assign tmask = '0;
`endif

endmodule

// File: tb/tb_logic_imm_decoder.sv
// Self-checking bench for logic_imm_decoder (scoreboard of expected results).
module tb_logic_imm_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic        n_bit;
    logic [5:0]  immr;
    logic [5:0]  imms;
    logic        ready;
    logic        done;
    logic        error;
    logic [63:0] wmask;
    logic [63:0] tmask;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [63:0] w;
        logic [63:0] t;
        logic        e;
        int          lat;
    } exp_t;

    exp_t sb[$];

    logic_imm_decoder #(.DATA_W(64)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .n_bit (n_bit),
        .immr  (immr),
        .imms  (imms),
        .ready (ready),
        .done  (done),
        .error (error),
        .wmask (wmask),
        .tmask (tmask)
    );

    always #5 clk = ~clk;

    // Bit-level reference: bit j of the result is bit (j mod esize) of the rotated element
    function automatic exp_t model(input logic n, input logic [5:0] r, input logic [5:0] s);
        exp_t x;
        int len, es, lv, sv, rv, d, k;
        logic [6:0] v;
        v = {n, ~s};
        len = -1;
        for (int i = 0; i < 7; i++) if (v[i]) len = i;
        x.w = '0; x.t = '0; x.e = 1'b0; x.lat = 2;
        if (len < 1) begin
            x.e = 1'b1;
            return x;
        end
        es = 1 << len;
        lv = es - 1;
        sv = int'(s) & lv;
        rv = int'(r) & lv;
        if (sv == lv) begin
            x.e = 1'b1;
            return x;
        end
        d = (sv - rv + es) % es;
        for (int j = 0; j < 64; j++) begin
            k = j % es;
            x.w[j] = (((k + rv) % es) <= sv);
`ifdef LOGIC_IMM_TMASK_EN
            x.t[j] = (k <= d);
`endif
        end
        x.lat = 3 + (6 - len);
        return x;
    endfunction

    task automatic send(input logic n, input logic [5:0] r, input logic [5:0] s);
        @(negedge clk);
        n_bit = n; immr = r; imms = s; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Latency counts the accepting edge as cycle 1
    task automatic wait_done(output int lat, output bit ok);
        lat = 1;
        ok  = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; start = 1'b0; n_bit = 1'b0; immr = '0; imms = '0;
        #2;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || wmask !== '0 || tmask !== '0) begin
            failures++;
            $display("FAIL reset_state: ready=%b done=%b error=%b wmask=%h tmask=%h, want 1 0 0 0 0",
                     ready, done, error, wmask, tmask);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed;
        bit          tn [7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        logic [5:0]  tr [7] = '{6'd0, 6'd0, 6'd0, 6'd1, 6'd0, 6'd0, 6'd0};
        logic [5:0]  ts [7] = '{6'b000000, 6'b000111, 6'b111100, 6'b000000,
                                6'b111111, 6'b111111, 6'b111101};
        logic [63:0] tw [7] = '{64'h0000000000000001, 64'h000000FF000000FF,
                                64'h5555555555555555, 64'h8000000000000000,
                                64'h0, 64'h0, 64'h0};
        logic [63:0] tt [7] = '{64'h0000000000000001, 64'h000000FF000000FF,
                                64'h5555555555555555, 64'hFFFFFFFFFFFFFFFF,
                                64'h0, 64'h0, 64'h0};
        bit          te [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        int          tl [7] = '{3, 4, 8, 3, 2, 2, 2};
        exp_t x;
        int   lat;
        bit   ok;
        for (int i = 0; i < 7; i++) begin
            x.w = tw[i]; x.e = te[i]; x.lat = tl[i];
`ifdef LOGIC_IMM_TMASK_EN
            x.t = tt[i];
`else
            x.t = '0;
`endif
            sb.push_back(x);
            send(tn[i], tr[i], ts[i]);
            wait_done(lat, ok);
            x = sb.pop_front();
            checks++;
            if (!ok || lat != x.lat) begin
                failures++;
                $display("FAIL dir%0d_latency: got %0d (done seen=%0b), want %0d", i, lat, ok, x.lat);
            end
            checks++;
            if (wmask !== x.w) begin
                failures++;
                $display("FAIL dir%0d_wmask: got %h, want %h", i, wmask, x.w);
            end
            checks++;
            if (tmask !== x.t) begin
                failures++;
                $display("FAIL dir%0d_tmask: got %h, want %h", i, tmask, x.t);
            end
            checks++;
            if (error !== x.e) begin
                failures++;
                $display("FAIL dir%0d_error: got %b, want %b", i, error, x.e);
            end
            @(posedge clk); #1;
            checks++;
            if (done !== 1'b0 || ready !== 1'b1) begin
                failures++;
                $display("FAIL dir%0d_pulse: done=%b ready=%b, want 0 1", i, done, ready);
            end
            repeat (2) @(posedge clk);
            #1;
            checks++;
            if (wmask !== x.w || error !== x.e) begin
                failures++;
                $display("FAIL dir%0d_hold: wmask=%h error=%b, want %h %b", i, wmask, error, x.w, x.e);
            end
        end
    endtask

    task automatic test_random;
        exp_t x;
        int   lat;
        bit   ok;
        logic n;
        logic [5:0] r, s;
        for (int i = 0; i < 24; i++) begin
            n = 1'($urandom_range(0, 1));
            r = 6'($urandom_range(0, 63));
            s = 6'($urandom_range(0, 63));
            sb.push_back(model(n, r, s));
            send(n, r, s);
            wait_done(lat, ok);
            x = sb.pop_front();
            checks++;
            if (!ok || lat != x.lat || wmask !== x.w || tmask !== x.t || error !== x.e) begin
                failures++;
                $display("FAIL rand%0d n=%b immr=%0d imms=%0d: lat=%0d wmask=%h tmask=%h err=%b, want lat=%0d wmask=%h tmask=%h err=%b",
                         i, n, r, s, lat, wmask, tmask, error, x.lat, x.w, x.t, x.e);
            end
        end
    endtask

    task automatic test_busy_start;
        exp_t x;
        int   lat;
        bit   ok;
        sb.push_back(model(1'b0, 6'd3, 6'b110011));
        send(1'b0, 6'd3, 6'b110011);
        start = 1'b1; n_bit = 1'b0; immr = 6'd5; imms = 6'b111111;
        checks++;
        if (ready !== 1'b0) begin
            failures++;
            $display("FAIL busy_ready: got %b, want 0", ready);
        end
        wait_done(lat, ok);
        start = 1'b0;
        x = sb.pop_front();
        checks++;
        if (!ok || lat != x.lat || wmask !== x.w || tmask !== x.t || error !== x.e) begin
            failures++;
            $display("FAIL busy_result: lat=%0d wmask=%h tmask=%h err=%b, want lat=%0d wmask=%h tmask=%h err=%b",
                     lat, wmask, tmask, error, x.lat, x.w, x.t, x.e);
        end
        @(posedge clk); #1;
        checks++;
        if (done !== 1'b0 || ready !== 1'b1) begin
            failures++;
            $display("FAIL busy_idle: done=%b ready=%b, want 0 1", done, ready);
        end
    endtask

    task automatic test_back_to_back;
        exp_t x;
        int   lat;
        bit   ok;
        sb.push_back(model(1'b0, 6'd2, 6'b100010));
        send(1'b0, 6'd2, 6'b100010);
        wait_done(lat, ok);
        x = sb.pop_front();
        checks++;
        if (!ok || lat != x.lat || wmask !== x.w || tmask !== x.t || error !== x.e) begin
            failures++;
            $display("FAIL b2b_first: lat=%0d wmask=%h err=%b, want lat=%0d wmask=%h err=%b",
                     lat, wmask, error, x.lat, x.w, x.e);
        end
        sb.push_back(model(1'b1, 6'd7, 6'd12));
        send(1'b1, 6'd7, 6'd12);
        checks++;
        if (ready !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL b2b_accept: ready=%b done=%b, want 0 0", ready, done);
        end
        wait_done(lat, ok);
        x = sb.pop_front();
        checks++;
        if (!ok || lat != x.lat || wmask !== x.w || tmask !== x.t || error !== x.e) begin
            failures++;
            $display("FAIL b2b_second: lat=%0d wmask=%h tmask=%h err=%b, want lat=%0d wmask=%h tmask=%h err=%b",
                     lat, wmask, tmask, error, x.lat, x.w, x.t, x.e);
        end
    endtask

    task automatic test_reset_mid;
        int pulses;
        send(1'b0, 6'd0, 6'b111100);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checks++;
        if (ready !== 1'b1 || done !== 1'b0 || error !== 1'b0 || wmask !== '0 || tmask !== '0) begin
            failures++;
            $display("FAIL reset_mid: ready=%b done=%b error=%b wmask=%h tmask=%h, want 1 0 0 0 0",
                     ready, done, error, wmask, tmask);
        end
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done === 1'b1 || wmask !== '0) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            failures++;
            $display("FAIL reset_no_done: %0d cycles with done/wmask set, want 0", pulses);
        end
    endtask

    initial begin
        test_reset;
        test_directed;
        test_random;
        test_busy_start;
        test_back_to_back;
        test_reset_mid;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
